// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler
//   Arbitrates the hard-reset, GoodCRC and message transmit requesters onto the single PHY TX
//   packet interface. It enforces an inter-frame gap after every PHY completion and holds off
//   non-hard-reset traffic while the receiver is busy. Failed messages are retried a bounded
//   number of times, and a missing PHY done is caught by a timeout.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_*_en / _type    level requests (hrst, gcrc, msg) and their packet types
//   sched_grant         one-hot active grant: [2]=hrst, [1]=gcrc, [0]=msg
//   sched_done          one-cycle completion pulse, same bit mapping as sched_grant
//   sched_result        valid with sched_done: 1=sent OK, 0=failed/timeout/abandoned
//   phy_rx_busy         receiver mid-packet; blocks gcrc/msg launches
//   phy_tx_en           one-cycle launch pulse to PHY TX control
//   phy_tx_type         packet type, held from launch until done
//   phy_tx_done         PHY completion pulse, with phy_tx_result (1=OK)
module phy_tx_scheduler #(
  parameter int unsigned IFG_CYCLES   = 300,
  parameter int unsigned RETRY_MAX    = 2,
  parameter int unsigned DONE_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_hrst_en,
  input  logic [2:0] req_hrst_type,
  input  logic       req_gcrc_en,
  input  logic [2:0] req_gcrc_type,
  input  logic       req_msg_en,
  input  logic [2:0] req_msg_type,
  output logic [2:0] sched_grant,
  output logic [2:0] sched_done,
  output logic       sched_result,
  input  logic       phy_rx_busy,
  output logic       phy_tx_en,
  output logic [2:0] phy_tx_type,
  input  logic       phy_tx_done,
  input  logic       phy_tx_result
);

  localparam logic [15:0] GapLoad  = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] ToLast   = 16'(DONE_TIMEOUT - 1);
  localparam logic [2:0]  RetryLim = 3'(RETRY_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StGap,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] to_q, to_d;
  logic [2:0]  retry_q, retry_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  type_q, type_d;
  logic        result_q, result_d;
  logic        tx_en_q;

  logic [2:0]  win_grant;
  logic [2:0]  win_type;
  logic        gap_zero;
  logic        timeout_hit;
  logic        can_retry;

  // Fixed priority; only hard reset may launch while the receiver is busy.
  always_comb begin
    win_grant = 3'b000;
    win_type  = 3'd0;
    if (req_hrst_en) begin
      win_grant = 3'b100;
      win_type  = req_hrst_type;
    end else if (!phy_rx_busy && req_gcrc_en) begin
      win_grant = 3'b010;
      win_type  = req_gcrc_type;
    end else if (!phy_rx_busy && req_msg_en) begin
      win_grant = 3'b001;
      win_type  = req_msg_type;
    end
  end

  assign gap_zero    = (gap_q == 16'd0);
  assign timeout_hit = (to_q == ToLast);
  assign can_retry   = grant_q[0] && (retry_q < RetryLim);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (gap_zero && (win_grant != 3'b000)) begin
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        // A done coinciding with the timeout cycle wins over the timeout.
        if (phy_tx_done) begin
          if (phy_tx_result) begin
            state_d = StResp;
          end else if (can_retry) begin
            state_d = StGap;
          end else begin
            state_d = StResp;
          end
        end else if (timeout_hit) begin
          state_d = StResp;
        end
      end
      StGap: begin
        // A hard-reset request abandons the pending message retry.
        if (req_hrst_en) begin
          state_d = StResp;
        end else if (gap_zero && !phy_rx_busy) begin
          state_d = StLaunch;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    gap_d    = gap_zero ? 16'd0 : (gap_q - 16'd1);
    to_d     = to_q;
    retry_d  = retry_q;
    grant_d  = grant_q;
    type_d   = type_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (state_d == StLaunch) begin
          grant_d = win_grant;
          type_d  = win_type;
        end
      end
      StLaunch: to_d = 16'd0;
      StWait: begin
        to_d     = to_q + 16'd1;
        result_d = phy_tx_done && phy_tx_result;
        if (state_d != StWait) begin
          gap_d = GapLoad;
        end
        if (state_d == StGap) begin
          retry_d = retry_q + 3'd1;
        end
      end
      StGap: begin
        if (state_d == StResp) begin
          result_d = 1'b0;
        end
      end
      StResp: begin
        grant_d = 3'b000;
        retry_d = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_q    <= 16'd0;
      to_q     <= 16'd0;
      retry_q  <= 3'd0;
      grant_q  <= 3'b000;
      type_q   <= 3'd0;
      result_q <= 1'b0;
      tx_en_q  <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      to_q     <= to_d;
      retry_q  <= retry_d;
      grant_q  <= grant_d;
      type_q   <= type_d;
      result_q <= result_d;
      // Launch pulse is registered so it coincides with the first WAIT cycle.
      tx_en_q  <= (state_q == StLaunch);
    end
  end

  // Outputs
  always_comb begin
    sched_grant  = grant_q;
    phy_tx_type  = type_q;
    phy_tx_en    = tx_en_q;
    sched_done   = 3'b000;
    sched_result = 1'b0;
    if (state_q == StResp) begin
      sched_done   = grant_q;
      sched_result = result_q;
    end
  end

endmodule

// File: tb/tb_phy_tx_scheduler.sv
module tb_phy_tx_scheduler;

  localparam int IFG  = 30;
  localparam int RMAX = 2;
  localparam int TO   = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_hrst_en = 1'b0, req_gcrc_en = 1'b0, req_msg_en = 1'b0;
  logic [2:0] req_hrst_type = 3'd0, req_gcrc_type = 3'd0, req_msg_type = 3'd0;
  logic       phy_rx_busy = 1'b0, phy_tx_done = 1'b0, phy_tx_result = 1'b0;
  logic [2:0] sched_grant, sched_done, phy_tx_type;
  logic       sched_result, phy_tx_en;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  phy_tx_scheduler #(
    .IFG_CYCLES  (IFG),
    .RETRY_MAX   (RMAX),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_hrst_en  (req_hrst_en),
    .req_hrst_type(req_hrst_type),
    .req_gcrc_en  (req_gcrc_en),
    .req_gcrc_type(req_gcrc_type),
    .req_msg_en   (req_msg_en),
    .req_msg_type (req_msg_type),
    .sched_grant  (sched_grant),
    .sched_done   (sched_done),
    .sched_result (sched_result),
    .phy_rx_busy  (phy_rx_busy),
    .phy_tx_en    (phy_tx_en),
    .phy_tx_type  (phy_tx_type),
    .phy_tx_done  (phy_tx_done),
    .phy_tx_result(phy_tx_result)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: bound expired, got no event, expected one (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------- PHY responder
  int   phy_lat = 0;
  bit   phy_lat_rand = 0;
  bit   phy_res_rand = 0;
  logic phy_res = 1'b1;
  bit   phy_spur = 0;
  bit   phy_kick = 0;
  int   phy_cnt = 0;

  always @(negedge clk) begin
    if (phy_tx_en) begin
      if (phy_lat_rand) phy_cnt = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12));
      else phy_cnt = phy_lat;
      if (phy_res_rand) phy_res = ($urandom_range(0, 2) != 0);
    end
  end

  always @(posedge clk) begin
    #2;
    phy_tx_done   = 1'b0;
    phy_tx_result = 1'b0;
    if (phy_kick) begin
      phy_tx_done   = 1'b1;
      phy_tx_result = 1'b1;
      phy_kick      = 0;
    end else if (phy_cnt > 0) begin
      phy_cnt--;
      if (phy_cnt == 0) begin
        phy_tx_done   = 1'b1;
        phy_tx_result = phy_res;
      end
    end else if (phy_spur && $urandom_range(0, 31) == 0) begin
      phy_tx_done   = 1'b1;
      phy_tx_result = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------- reference model
  // Transaction-level view: who owns the PHY, when its launch pulse is due, when the report
  // is due, and from which cycle a new decision is allowed after the inter-frame gap.
  bit         m_valid = 0, m_act = 0, m_ok = 0, m_retry = 0;
  int         m_who = 0, m_att = 0, m_en_at = -1, m_rep_at = -1, m_quiet = 0;
  logic [2:0] m_type = 3'd0;

  always @(negedge clk) begin
    logic [2:0] eg, ed;
    int w;
    if (m_valid) begin
      eg = m_act ? 3'(1 << m_who) : 3'b000;
      ed = (m_act && cyc == m_rep_at) ? eg : 3'b000;
      check("model grant", 32'(sched_grant), 32'(eg));
      check("model done", 32'(sched_done), 32'(ed));
      check("model result", 32'(sched_result), 32'(ed != 3'b000 && m_ok));
      check("model tx_en", 32'(phy_tx_en), 32'(m_act && cyc == m_en_at));
      check("model tx_type", 32'(phy_tx_type), 32'(m_type));
    end
    if (!rst_n) begin
      m_valid = 1; m_act = 0; m_retry = 0; m_type = 3'd0;
      m_en_at = -1; m_rep_at = -1; m_quiet = 0;
    end else if (m_valid) begin
      if (!m_act) begin
        w = -1;
        if (req_hrst_en) w = 2;
        else if (!phy_rx_busy && req_gcrc_en) w = 1;
        else if (!phy_rx_busy && req_msg_en) w = 0;
        if (w >= 0 && cyc >= m_quiet) begin
          m_act = 1; m_who = w; m_att = 1; m_retry = 0; m_rep_at = -1; m_en_at = cyc + 2;
          m_type = (w == 2) ? req_hrst_type : (w == 1) ? req_gcrc_type : req_msg_type;
        end
      end else if (m_rep_at == cyc) begin
        m_act = 0;
        m_rep_at = -1;
      end else if (m_rep_at >= 0) begin
        // report already scheduled
      end else if (m_retry) begin
        if (req_hrst_en) begin
          m_retry = 0; m_rep_at = cyc + 1; m_ok = 0;
        end else if (cyc >= m_quiet && !phy_rx_busy) begin
          m_retry = 0; m_en_at = cyc + 2;
        end
      end else if (cyc >= m_en_at) begin
        if (phy_tx_done) begin
          m_quiet = cyc + IFG;
          if (phy_tx_result) begin
            m_rep_at = cyc + 1; m_ok = 1;
          end else if (m_who == 0 && m_att <= RMAX) begin
            m_att++; m_retry = 1;
          end else begin
            m_rep_at = cyc + 1; m_ok = 0;
          end
        end else if (cyc - m_en_at == TO - 1) begin
          m_quiet = cyc + IFG; m_rep_at = cyc + 1; m_ok = 0;
        end
      end
    end
  end

  logic [2:0] done_seen = 3'b000;
  always @(negedge clk) done_seen = done_seen | sched_done;

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int limit, output int at, output logic [2:0] g);
    at = -1;
    g  = 3'b000;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (phy_tx_en) begin
        at = cyc;
        g  = sched_grant;
        break;
      end
    end
    if (at < 0) bound_fail("wait for phy_tx_en");
  endtask

  task automatic wait_done(input int limit, output int at, output logic [2:0] d, output logic r);
    at = -1;
    d  = 3'b000;
    r  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sched_done != 3'b000) begin
        at = cyc;
        d  = sched_done;
        r  = sched_result;
        break;
      end
    end
    if (at < 0) bound_fail("wait for sched_done");
  endtask

  // ---------------------------------------------------------------- directed + random
  initial begin
    int at, at2, dat, t0, n, last_phy_done;
    logic [2:0] g, d;
    logic r;
    logic [2:0] order_g [3];
    logic [2:0] order_d [3];

    repeat (3) tick();
    @(negedge clk);
    check("reset grant", 32'(sched_grant), 0);
    check("reset done", 32'(sched_done), 0);
    check("reset result", 32'(sched_result), 0);
    check("reset tx_en", 32'(phy_tx_en), 0);
    check("reset tx_type", 32'(phy_tx_type), 0);
    tick();
    rst_n = 1'b1;

    // Single message request
    tick();
    phy_lat = 8; phy_res = 1'b1;
    req_msg_en = 1'b1; req_msg_type = 3'd1;
    t0 = cyc;
    wait_en(10, at, g);
    check("single launch latency", 32'(at - t0), 2);
    check("single grant", 32'(g), 32'b001);
    check("single type", 32'(phy_tx_type), 1);
    wait_done(20, dat, d, r);
    check("single done cycle", 32'(dat - t0), 11);
    check("single done bits", 32'(d), 32'b001);
    check("single result", 32'(r), 1);
    wait_en(IFG + 20, at2, g);
    check("relaunch after gap", 32'(at2 - (dat - 1)), IFG + 2);
    wait_done(20, dat, d, r);
    tick();
    req_msg_en = 1'b0;

    // Simultaneous requests
    tick();
    phy_lat = 3;
    req_hrst_en = 1'b1; req_hrst_type = 3'd5;
    req_gcrc_en = 1'b1; req_gcrc_type = 3'd2;
    req_msg_en  = 1'b1; req_msg_type  = 3'd1;
    last_phy_done = 0;
    for (int k = 0; k < 3; k++) begin
      wait_en(IFG + 20, at, g);
      order_g[k] = g;
      if (k > 0) check("spacing after done", 32'(at - last_phy_done), IFG + 2);
      wait_done(20, dat, d, r);
      order_d[k] = d;
      last_phy_done = dat - 1;
      tick();
      if (d[2]) req_hrst_en = 1'b0;
      if (d[1]) req_gcrc_en = 1'b0;
      if (d[0]) req_msg_en = 1'b0;
    end
    check("order grant 0", 32'(order_g[0]), 32'b100);
    check("order grant 1", 32'(order_g[1]), 32'b010);
    check("order grant 2", 32'(order_g[2]), 32'b001);
    check("order done 0", 32'(order_d[0]), 32'b100);
    check("order done 1", 32'(order_d[1]), 32'b010);
    check("order done 2", 32'(order_d[2]), 32'b001);

    // Retry exhaustion
    repeat (IFG) tick();
    phy_res = 1'b0;
    req_msg_en = 1'b1;
    n = 0; d = 3'b000; r = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (phy_tx_en) n++;
      if (sched_done != 3'b000) begin
        d = sched_done; r = sched_result;
        break;
      end
    end
    check("retry launches", 32'(n), RMAX + 1);
    check("retry done bits", 32'(d), 32'b001);
    check("retry result", 32'(r), 0);
    tick();
    req_msg_en = 1'b0;

    // Hard-reset preemption during retry gap
    repeat (IFG) tick();
    req_msg_en = 1'b1;
    wait_en(20, at, g);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (phy_tx_done) n = 1;
    end
    if (n == 0) bound_fail("wait for phy_tx_done");
    repeat (3) tick();
    phy_res = 1'b1;
    req_hrst_en = 1'b1; req_hrst_type = 3'd6;
    wait_done(10, dat, d, r);
    check("preempt done bits", 32'(d), 32'b001);
    check("preempt result", 32'(r), 0);
    tick();
    req_msg_en = 1'b0;
    wait_en(IFG + 20, at, g);
    check("preempt hrst grant", 32'(g), 32'b100);
    check("preempt hrst type", 32'(phy_tx_type), 6);
    wait_done(20, dat, d, r);
    check("preempt hrst done", 32'(d), 32'b100);
    tick();
    req_hrst_en = 1'b0;

    // RX holdoff
    repeat (IFG) tick();
    phy_rx_busy = 1'b1;
    req_msg_en = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (phy_tx_en) n++;
    end
    check("holdoff msg launches", 32'(n), 0);
    tick();
    req_hrst_en = 1'b1;
    wait_en(10, at, g);
    check("holdoff hrst grant", 32'(g), 32'b100);
    wait_done(20, dat, d, r);
    tick();
    req_hrst_en = 1'b0;
    phy_rx_busy = 1'b0;
    wait_en(IFG + 20, at, g);
    check("holdoff released msg", 32'(g), 32'b001);
    wait_done(20, dat, d, r);
    tick();
    req_msg_en = 1'b0;

    // Done timeout
    repeat (IFG) tick();
    phy_lat = 0;
    req_msg_en = 1'b1;
    wait_en(10, at, g);
    wait_done(TO + 20, dat, d, r);
    check("timeout distance", 32'(dat - at), TO);
    check("timeout done bits", 32'(d), 32'b001);
    check("timeout result", 32'(r), 0);
    tick();
    req_msg_en = 1'b0;

    // Reset in the middle of WAIT
    repeat (IFG) tick();
    req_msg_en = 1'b1;
    wait_en(10, at, g);
    repeat (5) tick();
    rst_n = 1'b0;
    req_msg_en = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset grant", 32'(sched_grant), 0);
    check("midreset tx_en", 32'(phy_tx_en), 0);
    check("midreset type", 32'(phy_tx_type), 0);
    tick();
    phy_kick = 1;
    @(negedge clk);
    @(negedge clk);
    check("late done ignored", 32'(sched_done), 0);
    tick();
    phy_lat = 2;
    req_msg_en = 1'b1;
    t0 = cyc;
    wait_en(10, at, g);
    check("post-reset latency", 32'(at - t0), 2);
    wait_done(20, dat, d, r);
    tick();
    req_msg_en = 1'b0;

    // Randomized traffic, checked by the model every cycle
    phy_lat_rand = 1; phy_res_rand = 1; phy_spur = 1;
    for (int i = 0; i < 6000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 999) != 0);
      phy_rx_busy = ($urandom_range(0, 9) < 3);
      if (done_seen[2] || (req_hrst_en && $urandom_range(0, 199) == 0)) req_hrst_en = 1'b0;
      else if (!req_hrst_en && $urandom_range(0, 79) == 0) begin
        req_hrst_en = 1'b1; req_hrst_type = 3'($urandom_range(0, 7));
      end
      if (done_seen[1] || (req_gcrc_en && $urandom_range(0, 99) == 0)) req_gcrc_en = 1'b0;
      else if (!req_gcrc_en && $urandom_range(0, 19) == 0) begin
        req_gcrc_en = 1'b1; req_gcrc_type = 3'($urandom_range(0, 7));
      end
      if (done_seen[0] || (req_msg_en && $urandom_range(0, 99) == 0)) req_msg_en = 1'b0;
      else if (!req_msg_en && $urandom_range(0, 9) == 0) begin
        req_msg_en = 1'b1; req_msg_type = 3'($urandom_range(0, 7));
      end
      done_seen = 3'b000;
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
